// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and constants for the RV32M divider sequencer
package divider_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_operation_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIXUP,
        DONE
    } divider_state_e;

    localparam int ITERATIONS = 32;
    localparam int COUNT_W    = $clog2(ITERATIONS);

    function automatic logic is_signed_op(input div_operation_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem_op(input div_operation_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one combinational radix-2 restoring division iteration
module divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remainder,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remainder_next,
    output logic [WIDTH-1:0] dividend_next
);

    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;
    logic             quotient_bit;

    // The live remainder is always below the divisor, so the true difference
    // fits in WIDTH bits and the modular subtraction is exact.
    assign partial        = {remainder, dividend[WIDTH-1]};
    assign quotient_bit   = partial >= {1'b0, divisor};
    assign diff           = partial[WIDTH-1:0] - divisor;
    assign remainder_next = quotient_bit ? diff : partial[WIDTH-1:0];
    assign dividend_next  = {dividend[WIDTH-2:0], quotient_bit};

endmodule

// File: rtl/divider_sequencer.sv
// rtl/divider_sequencer.sv - multi-cycle DIV/DIVU/REM/REMU sequencer; DIVIDER_FAST_PATH_EN enables early finish
module divider_sequencer
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  div_operation_e   operation_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             kill_i,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    divider_state_e     state_q, state_d;
    div_operation_e     op_q;
    logic [COUNT_W-1:0] count_q;
    logic [WIDTH-1:0]   rem_q, dvd_q, dvs_q;
    logic [WIDTH-1:0]   rem_next, dvd_next;
    logic               dvd_neg_q, q_neg_q;

    logic               signed_in;
    logic [WIDTH-1:0]   dividend_mag, divisor_mag;
    logic [WIDTH-1:0]   quotient_fix, remainder_fix, result_fix;

    divider_step #(.WIDTH(WIDTH)) u_step (
        .remainder      (rem_q),
        .dividend       (dvd_q),
        .divisor        (dvs_q),
        .remainder_next (rem_next),
        .dividend_next  (dvd_next)
    );

    assign signed_in    = is_signed_op(operation_i);
    assign dividend_mag = (signed_in && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign divisor_mag  = (signed_in && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

    assign quotient_fix  = q_neg_q   ? -dvd_q : dvd_q;
    assign remainder_fix = dvd_neg_q ? -rem_q : rem_q;
    assign result_fix    = is_rem_op(op_q) ? remainder_fix : quotient_fix;

`ifdef DIVIDER_FAST_PATH_EN
    logic             fast_hit;
    logic [WIDTH-1:0] fast_result;

    // Both shortcut cases leave the dividend as remainder; only the quotient differs.
    assign fast_hit    = (divisor_i == '0) || (!signed_in && (dividend_i < divisor_i));
    assign fast_result = is_rem_op(operation_i) ? dividend_i :
                         (divisor_i == '0)      ? '1 : '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
`ifdef DIVIDER_FAST_PATH_EN
                    state_d = fast_hit ? DONE : BUSY;
`else
                    state_d = BUSY;
`endif
                end
            end
            BUSY:    if (count_q == '0) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            DONE:    if (result_valid_o && result_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    // Handshake outputs are registered copies of the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            ready_o        <= 1'b1;
            busy_o         <= 1'b0;
            result_valid_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            ready_o        <= (state_d == IDLE);
            busy_o         <= (state_d != IDLE);
            result_valid_o <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= DIV;
            count_q   <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            dvd_neg_q <= 1'b0;
            q_neg_q   <= 1'b0;
            result_o  <= '0;
        end else if (!kill_i) begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        op_q      <= operation_i;
                        count_q   <= COUNT_W'(ITERATIONS - 1);
                        rem_q     <= '0;
                        dvd_q     <= dividend_mag;
                        dvs_q     <= divisor_mag;
                        dvd_neg_q <= signed_in && dividend_i[WIDTH-1];
                        q_neg_q   <= signed_in && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1])
                                     && (divisor_i != '0);
`ifdef DIVIDER_FAST_PATH_EN
                        if (fast_hit) result_o <= fast_result;
`endif
                    end
                end
                BUSY: begin
                    rem_q   <= rem_next;
                    dvd_q   <= dvd_next;
                    count_q <= count_q - 1'b1;
                end
                FIXUP:   result_o <= result_fix;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_sequencer.sv
// tb/tb_divider_sequencer.sv - directed self-checking bench for divider_sequencer
module tb_divider_sequencer;
    import divider_pkg::*;

    localparam int SLOW_LAT = 34;
`ifdef DIVIDER_FAST_PATH_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = 34;
`endif

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           valid_i;
    logic           ready_o;
    div_operation_e operation_i;
    logic [31:0]    dividend_i;
    logic [31:0]    divisor_i;
    logic           kill_i;
    logic           result_valid_o;
    logic           result_ready_i;
    logic [31:0]    result_o;
    logic           busy_o;

    int checks = 0;
    int errors = 0;

    divider_sequencer #(.WIDTH(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .operation_i    (operation_i),
        .dividend_i     (dividend_i),
        .divisor_i      (divisor_i),
        .kill_i         (kill_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic run_op(input div_operation_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name);
        int lat;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: ready_o=%b want 1", name, ready_o);
        end
        operation_i = op; dividend_i = a; divisor_i = b; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1;
        checks++;
        if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy_o=%b ready_o=%b want busy_o=1 ready_o=0", name, busy_o, ready_o);
        end
        while (result_valid_o !== 1'b1 && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (result_o !== exp) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, result_o, exp);
        end
        result_ready_i = 1'b1;
        @(posedge clk_i); #1;
        result_ready_i = 1'b0;
        checks++;
        if (result_valid_o !== 1'b0 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s release: valid=%b ready=%b busy=%b want 0 1 0",
                     name, result_valid_o, ready_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; kill_i = 1'b0; result_ready_i = 1'b0;
        operation_i = DIV; dividend_i = '0; divisor_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || result_valid_o !== 1'b0 || result_o !== 32'h0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b result=%h busy=%b want 1 0 0 0",
                     ready_o, result_valid_o, result_o, busy_o);
        end
    endtask

    task automatic test_unsigned();
        run_op(DIVU, 32'd100, 32'd7, 32'd14, SLOW_LAT, "divu_100_7");
        run_op(REMU, 32'd100, 32'd7, 32'd2,  SLOW_LAT, "remu_100_7");
        run_op(DIVU, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, SLOW_LAT, "divu_max_16");
    endtask

    task automatic test_signed();
        run_op(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, SLOW_LAT, "div_m7_2");
        run_op(REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, SLOW_LAT, "rem_m7_2");
        run_op(DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, SLOW_LAT, "div_7_m2");
        run_op(REM, 32'd7, 32'hFFFFFFFE, 32'd1,        SLOW_LAT, "rem_7_m2");
    endtask

    task automatic test_div_zero();
        run_op(DIV,  32'h12345678, 32'h0, 32'hFFFFFFFF, FAST_LAT, "div_by_zero");
        run_op(REM,  32'h12345678, 32'h0, 32'h12345678, FAST_LAT, "rem_by_zero");
        run_op(DIVU, 32'h12345678, 32'h0, 32'hFFFFFFFF, FAST_LAT, "divu_by_zero");
        run_op(REM,  32'h80000001, 32'h0, 32'h80000001, FAST_LAT, "rem_neg_by_zero");
    endtask

    task automatic test_overflow();
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SLOW_LAT, "div_overflow");
        run_op(REM, 32'h80000000, 32'hFFFFFFFF, 32'h0,        SLOW_LAT, "rem_overflow");
    endtask

    task automatic test_small_dividend();
        run_op(DIVU, 32'd5, 32'd9, 32'd0, FAST_LAT, "divu_small");
        run_op(REMU, 32'd5, 32'd9, 32'd5, FAST_LAT, "remu_small");
        run_op(DIV,  32'd5, 32'd9, 32'd0, SLOW_LAT, "div_small_signed");
    endtask

    task automatic test_kill();
        operation_i = DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        // Counter reaches 10 after the 21st step edge.
        repeat (21) @(posedge clk_i);
        #1 kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || result_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_busy: ready=%b busy=%b valid=%b want 1 0 0", ready_o, busy_o, result_valid_o);
        end
        run_op(DIVU, 32'd9, 32'd3, 32'd3, SLOW_LAT, "after_kill");

        operation_i = DIVU; dividend_i = 32'd9; divisor_i = 32'd3;
        valid_i = 1'b1; kill_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL kill_with_valid: busy=%b ready=%b want 0 1", busy_o, ready_o);
        end
    endtask

    task automatic test_hold();
        int lat;
        operation_i = DIVU; dividend_i = 32'd1000; divisor_i = 32'd10; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1;
        while (result_valid_o !== 1'b1 && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
        end
        checks++;
        if (lat !== SLOW_LAT) begin
            errors++;
            $display("FAIL hold_latency: got %0d want %0d", lat, SLOW_LAT);
        end
        valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (result_valid_o !== 1'b1 || result_o !== 32'd100 || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle_%0d: valid=%b result=%h ready=%b want 1 00000064 0",
                         i, result_valid_o, result_o, ready_o);
            end
        end
        valid_i = 1'b0;
        result_ready_i = 1'b1;
        @(posedge clk_i); #1;
        result_ready_i = 1'b0;
        checks++;
        if (result_valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: valid=%b ready=%b want 0 1", result_valid_o, ready_o);
        end
    endtask

    task automatic test_back_to_back();
        run_op(DIVU, 32'd50,  32'd5, 32'd10, SLOW_LAT, "b2b_first");
        run_op(REMU, 32'd53,  32'd5, 32'd3,  SLOW_LAT, "b2b_second");
    endtask

    task automatic test_reset_busy();
        operation_i = DIVU; dividend_i = 32'd100; divisor_i = 32'd7; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || result_valid_o !== 1'b0 || result_o !== 32'h0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_busy: ready=%b valid=%b result=%h busy=%b want 1 0 0 0",
                     ready_o, result_valid_o, result_o, busy_o);
        end
        run_op(DIVU, 32'd9, 32'd3, 32'd3, SLOW_LAT, "after_reset");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_small_dividend();
        test_kill();
        test_hold();
        test_back_to_back();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
